// File: rtl/sn157_nibble_reader.sv
// Purpose: reads one byte through an external SN74XX157 quad 2:1 mux as two nibbles (A then B).
// Latency: valid pulses 2*SETTLE edges after the edge that accepts start; one byte per 2*SETTLE+1 cycles when start is held.
// Backpressure: none; start is taken only in IDLE and dropped while busy, and data/valid are not held back by any consumer.
`timescale 1ns/1ps

module sn157_nibble_reader #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mux_y,
  output logic       sel,
  output logic       str,
  output logic       busy,
  output logic [7:0] data,
  output logic       valid
);

  // Reload value for the settle counter; a window of SETTLE cycles counts SETTLE-1 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL_A = 2'd1,
    SEL_B = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] lo, lo_n;
  logic       sel_n, str_n, busy_n, valid_n;
  logic [7:0] data_n;

  // State and every output are registered; reset parks the mux disabled with select on A.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      lo    <= 4'd0;
      sel   <= 1'b0;
      str   <= 1'b1;
      busy  <= 1'b0;
      data  <= 8'h00;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lo    <= lo_n;
      sel   <= sel_n;
      str   <= str_n;
      busy  <= busy_n;
      data  <= data_n;
      valid <= valid_n;
    end
  end

  // Next-state and next-output logic; nibbles are sampled only on the last cycle of each select window.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lo_n    = lo;
    sel_n   = sel;
    str_n   = str;
    busy_n  = busy;
    data_n  = data;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEL_A;
          sel_n   = 1'b0;
          str_n   = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = CNT_INIT;
        end
      end
      SEL_A: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          // Strobe stays low across the A->B switch so the mux never glitches to disabled mid-read.
          lo_n    = mux_y;
          state_n = SEL_B;
          sel_n   = 1'b1;
          cnt_n   = CNT_INIT;
        end
      end
      SEL_B: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          data_n  = {mux_y, lo};
          valid_n = 1'b1;
          str_n   = 1'b1;
          busy_n  = 1'b0;
          sel_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        str_n   = 1'b1;
        busy_n  = 1'b0;
        sel_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sn157_nibble_reader.sv
// Purpose: directed bench for sn157_nibble_reader with SETTLE=1 and SETTLE=3 instances, each driving a behavioural '157 mux.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Backpressure: not applicable; stimulus is a fixed linear sequence of clock ticks.
`timescale 1ns/1ps

module tb_sn157_nibble_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [3:0] a1, b1, a3, b3;
  logic [3:0] y1, y3;
  logic       sel1, str1, busy1, valid1;
  logic       sel3, str3, busy3, valid3;
  logic [7:0] data1, data3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural SN74XX157: strobe high forces Y low, otherwise select picks B (1) or A (0).
  assign y1 = str1 ? 4'h0 : (sel1 ? b1 : a1);
  assign y3 = str3 ? 4'h0 : (sel3 ? b3 : a3);

  sn157_nibble_reader #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mux_y(y1),
    .sel(sel1), .str(str1), .busy(busy1), .data(data1), .valid(valid1)
  );

  sn157_nibble_reader #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mux_y(y3),
    .sel(sel3), .str(str3), .busy(busy3), .data(data3), .valid(valid3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st1(input string tag, input logic es, input logic et, input logic eb,
                     input logic ev, input logic [7:0] ed);
    chk1({tag, "_sel1"}, sel1, es);
    chk1({tag, "_str1"}, str1, et);
    chk1({tag, "_busy1"}, busy1, eb);
    chk1({tag, "_valid1"}, valid1, ev);
    chk8({tag, "_data1"}, data1, ed);
  endtask

  task automatic st3(input string tag, input logic es, input logic et, input logic eb,
                     input logic ev, input logic [7:0] ed);
    chk1({tag, "_sel3"}, sel3, es);
    chk1({tag, "_str3"}, str3, et);
    chk1({tag, "_busy3"}, busy3, eb);
    chk1({tag, "_valid3"}, valid3, ev);
    chk8({tag, "_data3"}, data3, ed);
  endtask

  initial begin
    logic [11:0] pat;
    int vcnt, bcnt, vat, phase;

    // Reset held two cycles with start asserted: outputs stay at reset values.
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1;
    a1 = 4'hA; b1 = 4'h5; a3 = 4'h3; b3 = 4'h9;
    for (int i = 0; i < 2; i++) begin
      tick;
      st1("rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      st3("rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end

    // Single read at SETTLE=1; start present on the first edge without reset.
    rst = 1'b0; start3 = 1'b0;
    tick; st1("one_e1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    start1 = 1'b0;
    tick; st1("one_e2", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st1("one_e3", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    tick; st1("one_e4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);

    // Start held for 10 cycles: a byte every 3 cycles, busy low only with valid.
    start1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      phase = (k - 1) % 3;
      if (phase == 2) st1("held_v", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
      else            st1("held_b", (phase == 1), 1'b0, 1'b1, 1'b0, 8'h5A);
    end
    start1 = 1'b0;
    tick; st1("held_drain_b", 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    tick; st1("held_drain_v", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    tick; st1("held_idle", 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);

    // SETTLE=3: A is 3 for the first two SEL_A cycles then C; only the last value counts.
    a3 = 4'h3; start3 = 1'b1;
    tick; st3("s3_e0", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    start3 = 1'b0;
    tick; st3("s3_e1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st3("s3_e2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    a3 = 4'hC;
    tick; st3("s3_e3", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st3("s3_e4", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st3("s3_e5", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st3("s3_e6", 1'b0, 1'b1, 1'b0, 1'b1, 8'h9C);
    tick; st3("s3_e7", 1'b0, 1'b1, 1'b0, 1'b0, 8'h9C);

    // Start re-pulsed during SEL_A and SEL_B: exactly one byte, busy for 6 cycles.
    pat = 12'h015;
    vcnt = 0; bcnt = 0; vat = -1;
    for (int i = 0; i < 12; i++) begin
      start3 = pat[i];
      tick;
      if (valid3) begin vcnt++; vat = i; end
      if (busy3) bcnt++;
    end
    start3 = 1'b0;
    chk8("repulse_valid_cnt", 8'(vcnt), 8'd1);
    chk8("repulse_valid_at", 8'(vat), 8'd6);
    chk8("repulse_busy_cnt", 8'(bcnt), 8'd6);
    chk8("repulse_data", data3, 8'h9C);

    // Reset during SEL_B after a completed 5A byte: read aborted, data cleared.
    start1 = 1'b1;
    tick; st1("abort_a", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    start1 = 1'b0;
    tick; st1("abort_b", 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    rst = 1'b1;
    tick; st1("abort_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk8("abort_rst_data3", data3, 8'h00);
    rst = 1'b0;
    tick; st1("abort_idle1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick; st1("abort_idle2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    start1 = 1'b1;
    tick; st1("after_e1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    start1 = 1'b0;
    tick; st1("after_e2", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick; st1("after_e3", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    tick; st1("after_e4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn157_nibble_reader.md
SN157_NIBBLE_READER -- requirements
Module: sn157_nibble_reader

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each mux input stays selected before its nibble is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one byte read; sampled only in IDLE.
REQ-005 SHALL have port mux_y  input  4  Y outputs of the downstream SN74XX157 quad 2:1 mux.
REQ-006 SHALL have port sel  output  1  mux select; 0 = A inputs, 1 = B inputs.
REQ-007 SHALL have port str  output  1  mux strobe, active-low enable; 1 forces mux_y to 0.
REQ-008 SHALL have port busy  output  1  read in progress.
REQ-009 SHALL have port data  output  8  assembled byte, {B nibble, A nibble}.
REQ-010 SHALL have port valid  output  1  one-cycle pulse; data is new this cycle.

Function
REQ-011 SHALL implement states IDLE, SEL_A, SEL_B with a 4-bit settle counter cnt; all outputs registered.
REQ-012 IDLE: str=1, busy=0; start=1 at an edge -> SEL_A, sel=0, str=0, busy=1, cnt=SETTLE-1.
REQ-013 IDLE with start=0 SHALL hold state; sel and data unchanged.
REQ-014 SEL_A: cnt!=0 -> cnt decrements; cnt==0 -> latch mux_y into internal lo nibble, go SEL_B, sel=1, cnt=SETTLE-1; str stays 0.
REQ-015 SEL_B: cnt!=0 -> cnt decrements; cnt==0 -> data={mux_y, lo}, valid=1, str=1, busy=0, sel=0, go IDLE.
REQ-016 valid SHALL be high exactly one cycle per completed read; data SHALL change only on that edge and hold otherwise.
REQ-017 Latency: valid rises 2*SETTLE edges after the edge that sampled start; busy high for exactly 2*SETTLE cycles.
REQ-018 Sampled nibble SHALL be mux_y on the last cycle of each select window; earlier values ignored.
REQ-019 start while busy SHALL be ignored, not queued.
REQ-020 start high in the valid cycle (state IDLE) SHALL be accepted; held start yields one byte every 2*SETTLE+1 cycles.
REQ-021 sel SHALL only change while str=0 at the SEL_A->SEL_B transition, or together with str going to 1.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, sel=0, str=1, busy=0, valid=0, data=8'h00, lo=0, cnt=0, overriding start.
REQ-023 rst during SEL_A or SEL_B SHALL abort the read with no valid pulse; partial nibble discarded.
REQ-024 First start accepted on the first edge with rst=0.

Verification
REQ-025 Reset: rst=1 two cycles, start=1 -> sel=0, str=1, busy=0, valid=0, data=8'h00 throughout.
REQ-026 SETTLE=1, real SN74XX157 model with A=4'hA, B=4'h5, one-cycle start -> sel 0 then 1, str low 2 cycles, valid one cycle 2 edges after start, data=8'h5A.
REQ-027 SETTLE=1, start held high 10 cycles, A/B=A/5 -> valid every 3 cycles, data=8'h5A each time, busy low only in valid cycles.
REQ-028 SETTLE=3, A=4'h3 first two cycles of SEL_A then 4'hC, B=4'h9 -> data=8'h9C, valid 6 edges after start.
REQ-029 start re-pulsed during SEL_A and SEL_B -> exactly one valid; busy 2*SETTLE cycles.
REQ-030 rst pulsed during SEL_B after a prior byte 8'h5A -> no valid, data=8'h00, next start completes normally.
